board_move_writer: RTL



---
 rtl/board_move_writer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/board_move_writer.sv
`timescale 1ns/1ps
// board_move_writer: applies one chess move to the shared board register as two write-port cycles.
// Optional feature: define BOARD_MOVE_PROMOTE_EN to turn pawns reaching the last rank into queens.
//
// state  | meaning
// IDLE   | ready, waiting for a move command
// CHECK  | latched command under validation
// WR_DST | writing the mover onto the destination square
// WR_SRC | clearing the source square
// DONE   | move complete pulse
// ERR    | command rejected pulse, nothing written
module board_move_writer #(
    parameter logic [3:0] NONE_CODE = 4'b0000
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic [255:0] BOARD,
    input  logic         MOVE_VALID,
    input  logic [5:0]   MOVE_SRC,
    input  logic [5:0]   MOVE_DST,
    output logic         MOVE_READY,
    output logic [5:0]   BOARD_ADDR,
    output logic [3:0]   BOARD_PIECE,
    output logic         BOARD_WE,
    output logic         MOVE_DONE,
    output logic         MOVE_ERR,
    output logic [3:0]   CAPTURED
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        WR_DST = 3'd2,
        WR_SRC = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    localparam logic [2:0] PIECE_NONE  = 3'b000;
    localparam logic [2:0] PIECE_QUEEN = 3'b101;

    state_t     state;
    state_t     state_nxt;

    logic [5:0] src_q;
    logic [5:0] dst_q;
    logic [3:0] mover_q;
    logic [3:0] write_piece;
    logic       accept;
    logic       reject;

    logic       ready_nxt;
    logic       we_nxt;
    logic       done_nxt;
    logic       err_nxt;
    logic [5:0] addr_nxt;
    logic [3:0] piece_nxt;

    // READY is itself a register, so accept coincides exactly with being in IDLE.
    assign accept = MOVE_VALID && MOVE_READY;

    assign reject = (mover_q[2:0] == PIECE_NONE)
                 || (src_q == dst_q)
                 || ((CAPTURED[2:0] != PIECE_NONE) && (CAPTURED[3] == mover_q[3]));

`ifdef BOARD_MOVE_PROMOTE_EN
    // Row 0 is the far rank for white, row 7 for black.
    always_comb begin
        write_piece = mover_q;
        if ((mover_q == 4'b0001 && dst_q[5:3] == 3'd0) ||
            (mover_q == 4'b1001 && dst_q[5:3] == 3'd7)) begin
            write_piece = {mover_q[3], PIECE_QUEEN};
        end
    end
`else
    assign write_piece = mover_q;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CHECK;
            CHECK:   state_nxt = reject ? ERR : WR_DST;
            WR_DST:  state_nxt = WR_SRC;
            WR_SRC:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each port
    // reflects the state the FSM is in during that cycle.
    always_comb begin
        ready_nxt = (state_nxt == IDLE);
        we_nxt    = 1'b0;
        done_nxt  = (state_nxt == DONE);
        err_nxt   = (state_nxt == ERR);
        addr_nxt  = 6'd0;
        piece_nxt = 4'd0;
        case (state_nxt)
            WR_DST: begin
                we_nxt    = 1'b1;
                addr_nxt  = dst_q;
                piece_nxt = write_piece;
            end
            WR_SRC: begin
                we_nxt    = 1'b1;
                addr_nxt  = src_q;
                piece_nxt = NONE_CODE;
            end
            default: begin
                we_nxt    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            MOVE_READY  <= 1'b1;
            BOARD_WE    <= 1'b0;
            BOARD_ADDR  <= 6'd0;
            BOARD_PIECE <= 4'd0;
            MOVE_DONE   <= 1'b0;
            MOVE_ERR    <= 1'b0;
        end else begin
            MOVE_READY  <= ready_nxt;
            BOARD_WE    <= we_nxt;
            BOARD_ADDR  <= addr_nxt;
            BOARD_PIECE <= piece_nxt;
            MOVE_DONE   <= done_nxt;
            MOVE_ERR    <= err_nxt;
        end
    end

    // The board is sampled only at accept; later board changes cannot disturb the move.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            src_q    <= 6'd0;
            dst_q    <= 6'd0;
            mover_q  <= 4'd0;
            CAPTURED <= 4'd0;
        end else if (accept) begin
            src_q    <= MOVE_SRC;
            dst_q    <= MOVE_DST;
            mover_q  <= BOARD[{MOVE_SRC, 2'b00} +: 4];
            CAPTURED <= BOARD[{MOVE_DST, 2'b00} +: 4];
        end
    end

endmodule
